// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Turns the ALU result into a
// word-aligned req/ack bus access with byte enables and lane-replicated store
// data, flags AdEL/AdES address faults, stalls the pipeline while a bus access
// is outstanding, and returns sign/zero-extended load data.
// Optional feature: define MEM_ACCESS_TIMEOUT_EN to raise a DBE bus error when
// bus_ack does not arrive within TIMEOUT_CYCLES request cycles.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush,
  input  logic [3:0]  MemOp,
  input  logic [31:0] Addr,
  input  logic        AddrOv,
  input  logic [31:0] WData,
  output logic        stall,
  output logic        done,
  output logic [31:0] RData,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4,
    OP_LBU  = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB  = 4'd8
  } mem_op_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [4:0]  code_q, code_d;
  logic [1:0]  off_q, off_d;
  logic        word_q, word_d;
  logic        half_q, half_d;
  logic        sext_q, sext_d;
  logic        flushed_q, flushed_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  logic        is_load, is_store, sz_word, sz_half, ld_sext;
  logic        start, fault;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Decode the memory-op code into direction, access size and extension.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sz_word  = 1'b0;
    sz_half  = 1'b0;
    ld_sext  = 1'b0;
    case (mem_op_e'(MemOp))
      OP_LW:   begin is_load  = 1'b1; sz_word = 1'b1; end
      OP_LH:   begin is_load  = 1'b1; sz_half = 1'b1; ld_sext = 1'b1; end
      OP_LHU:  begin is_load  = 1'b1; sz_half = 1'b1; end
      OP_LB:   begin is_load  = 1'b1; ld_sext = 1'b1; end
      OP_LBU:  begin is_load  = 1'b1; end
      OP_SW:   begin is_store = 1'b1; sz_word = 1'b1; end
      OP_SH:   begin is_store = 1'b1; sz_half = 1'b1; end
      OP_SB:   begin is_store = 1'b1; end
      default: begin end
    endcase
  end

  // Address check, byte enables and lane-replicated store data for a new access.
  always_comb begin
    start = valid_in && !flush && (is_load || is_store);
    fault = AddrOv || (sz_word && (Addr[1:0] != 2'b00)) || (sz_half && Addr[0]);
    if (sz_word)      be_new = 4'b1111;
    else if (sz_half) be_new = Addr[1] ? 4'b1100 : 4'b0011;
    else              be_new = 4'b0001 << Addr[1:0];
    if (!is_store)    wdata_new = '0;
    else if (sz_word) wdata_new = WData;
    else if (sz_half) wdata_new = {2{WData[15:0]}};
    else              wdata_new = {4{WData[7:0]}};
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    if (word_q)      ld_ext = bus_rdata;
    else if (half_q) ld_ext = {{16{sext_q & ld_half[15]}}, ld_half};
    else             ld_ext = {{24{sext_q & ld_byte[7]}}, ld_byte};
  end

  // Next-state logic: IDLE -> (REQ ->) DONE -> IDLE, with flush dropping the DONE cycle.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    exc_d     = exc_q;
    code_d    = code_q;
    off_d     = off_q;
    word_d    = word_q;
    half_d    = half_q;
    sext_d    = sext_q;
    flushed_d = flushed_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (fault) begin
            state_d = S_DONE;
            exc_d   = 1'b1;
            code_d  = is_load ? 5'd4 : 5'd5;
            rdata_d = '0;
          end else begin
            state_d   = S_REQ;
            req_d     = 1'b1;
            we_d      = is_store;
            addr_d    = {Addr[31:2], 2'b00};
            be_d      = be_new;
            wdata_d   = wdata_new;
            off_d     = Addr[1:0];
            word_d    = sz_word;
            half_d    = sz_half;
            sext_d    = ld_sext;
            exc_d     = 1'b0;
            code_d    = '0;
            flushed_d = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d     = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (flush) flushed_d = 1'b1;
        if (bus_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? '0 : ld_ext;
          state_d = (flush || flushed_q) ? S_IDLE : S_DONE;
        end
`ifdef MEM_ACCESS_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          req_d   = 1'b0;
          exc_d   = 1'b1;
          code_d  = 5'd7;
          rdata_d = '0;
          state_d = (flush || flushed_q) ? S_IDLE : S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bus-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      exc_q     <= 1'b0;
      code_q    <= '0;
      off_q     <= '0;
      word_q    <= 1'b0;
      half_q    <= 1'b0;
      sext_q    <= 1'b0;
      flushed_q <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      exc_q     <= exc_d;
      code_q    <= code_d;
      off_q     <= off_d;
      word_q    <= word_d;
      half_q    <= half_d;
      sext_q    <= sext_d;
      flushed_q <= flushed_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign stall     = ((state_q == S_IDLE) && start) || (state_q == S_REQ);
  assign done      = (state_q == S_DONE) && !flush;
  assign exc_valid = done && exc_q;
  assign exc_code  = exc_valid ? code_q : '0;
  assign RData     = (state_q == S_DONE) ? rdata_q : '0;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule
